// File: rtl/fb_read_arbiter.sv
// Read-port arbiter for the QVGA frame buffer: display has absolute priority, aux reads fill idle slots.
// Optional statistics counters are built when FB_ARB_STATS_EN is defined.
module fb_read_arbiter #(
    parameter int unsigned ADDR_W       = 17,
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned RD_LATENCY   = 1,
    parameter int unsigned STARVE_LIMIT = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              disp_en,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_valid,
    input  logic              aux_req,
    input  logic [ADDR_W-1:0] aux_addr,
    output logic              aux_gnt,
    output logic [DATA_W-1:0] aux_data,
    output logic              aux_valid,
    output logic              aux_starve,
    output logic              fb_en,
    output logic [ADDR_W-1:0] fb_addr,
    input  logic [DATA_W-1:0] fb_rdata
`ifdef FB_ARB_STATS_EN
    ,
    input  logic              stats_clr,
    output logic [15:0]       aux_grant_cnt,
    output logic [16:0]       disp_read_cnt
`endif
);

    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DISP = 2'd1,
        ST_AUX  = 2'd2
    } owner_t;

    owner_t             w_owner;
    logic               w_aux_gnt;
    owner_t             r_state;
    logic               r_fb_en;
    logic [ADDR_W-1:0]  r_fb_addr;
    owner_t             r_tag [RD_LATENCY];
    owner_t             w_ret;
    logic               r_disp_valid;
    logic               r_aux_valid;
    logic [DATA_W-1:0]  r_disp_data;
    logic [DATA_W-1:0]  r_aux_data;
    logic [CNT_W-1:0]   r_starve_cnt;
    logic [CNT_W-1:0]   w_starve_cnt_nxt;
    logic               r_aux_starve;

    // Fixed-priority owner selection; no grant can leak out while in reset.
    always_comb begin
        w_owner   = ST_IDLE;
        w_aux_gnt = 1'b0;
        if (disp_en) begin
            w_owner = ST_DISP;
        end else if (aux_req && rst_n) begin
            w_owner   = ST_AUX;
            w_aux_gnt = 1'b1;
        end
    end

    // Issue FSM: state is the owner of the current frame-buffer slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_fb_en   <= 1'b0;
            r_fb_addr <= '0;
        end else begin
            r_state <= w_owner;
            r_fb_en <= (w_owner != ST_IDLE);
            case (w_owner)
                ST_DISP: r_fb_addr <= disp_addr;
                ST_AUX:  r_fb_addr <= aux_addr;
                default: r_fb_addr <= r_fb_addr;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(RD_LATENCY); i++) r_tag[i] <= ST_IDLE;
        end else begin
            r_tag[0] <= r_state;
            for (int i = 1; i < int'(RD_LATENCY); i++) r_tag[i] <= r_tag[i-1];
        end
    end

    assign w_ret = r_tag[RD_LATENCY-1];

    // Capture returning data into the owner's register; the other side holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_disp_valid <= 1'b0;
            r_aux_valid  <= 1'b0;
            r_disp_data  <= '0;
            r_aux_data   <= '0;
        end else begin
            r_disp_valid <= (w_ret == ST_DISP);
            r_aux_valid  <= (w_ret == ST_AUX);
            if (w_ret == ST_DISP) r_disp_data <= fb_rdata;
            if (w_ret == ST_AUX)  r_aux_data  <= fb_rdata;
        end
    end

    always_comb begin
        w_starve_cnt_nxt = '0;
        if (aux_req && !w_aux_gnt) begin
            if (r_starve_cnt == CNT_W'(STARVE_LIMIT)) w_starve_cnt_nxt = r_starve_cnt;
            else                                     w_starve_cnt_nxt = r_starve_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve_cnt <= '0;
            r_aux_starve <= 1'b0;
        end else begin
            r_starve_cnt <= w_starve_cnt_nxt;
            r_aux_starve <= (w_starve_cnt_nxt == CNT_W'(STARVE_LIMIT));
        end
    end

`ifdef FB_ARB_STATS_EN
    logic [15:0] r_aux_grant_cnt;
    logic [16:0] r_disp_read_cnt;

    // Saturating usage counters; a clear beats a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_aux_grant_cnt <= '0;
            r_disp_read_cnt <= '0;
        end else if (stats_clr) begin
            r_aux_grant_cnt <= '0;
            r_disp_read_cnt <= '0;
        end else begin
            if (w_aux_gnt && (r_aux_grant_cnt != '1))
                r_aux_grant_cnt <= r_aux_grant_cnt + 16'(1);
            if ((w_owner == ST_DISP) && (r_disp_read_cnt != '1))
                r_disp_read_cnt <= r_disp_read_cnt + 17'(1);
        end
    end

    assign aux_grant_cnt = r_aux_grant_cnt;
    assign disp_read_cnt = r_disp_read_cnt;
`else
    // Statistics counters are not built in this configuration.
`endif

    assign aux_gnt    = w_aux_gnt;
    assign fb_en      = r_fb_en;
    assign fb_addr    = r_fb_addr;
    assign disp_valid = r_disp_valid;
    assign disp_data  = r_disp_data;
    assign aux_valid  = r_aux_valid;
    assign aux_data   = r_aux_data;
    assign aux_starve = r_aux_starve;

endmodule

// File: tb/tb_fb_read_arbiter.sv
// Scoreboard bench for fb_read_arbiter: stimulus pushes expected returns, a monitor pops and compares.
module tb_fb_read_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        disp_en;
    logic [16:0] disp_addr;
    logic [15:0] disp_data;
    logic        disp_valid;
    logic        aux_req;
    logic [16:0] aux_addr;
    logic        aux_gnt;
    logic [15:0] aux_data;
    logic        aux_valid;
    logic        aux_starve;
    logic        fb_en;
    logic [16:0] fb_addr;
    logic [15:0] fb_rdata;
`ifdef FB_ARB_STATS_EN
    logic        stats_clr;
    logic [15:0] aux_grant_cnt;
    logic [16:0] disp_read_cnt;
`endif

    typedef struct {
        logic        is_aux;
        logic [15:0] data;
        int          due;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic        exp_fb_en;
    logic [16:0] exp_fb_addr;

    always #5 clk = ~clk;

    fb_read_arbiter #(
        .ADDR_W(17), .DATA_W(16), .RD_LATENCY(1), .STARVE_LIMIT(1023)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .disp_en(disp_en), .disp_addr(disp_addr), .disp_data(disp_data), .disp_valid(disp_valid),
        .aux_req(aux_req), .aux_addr(aux_addr), .aux_gnt(aux_gnt), .aux_data(aux_data),
        .aux_valid(aux_valid), .aux_starve(aux_starve),
        .fb_en(fb_en), .fb_addr(fb_addr), .fb_rdata(fb_rdata)
`ifdef FB_ARB_STATS_EN
        , .stats_clr(stats_clr), .aux_grant_cnt(aux_grant_cnt), .disp_read_cnt(disp_read_cnt)
`endif
    );

    function automatic logic [15:0] fb_model(input logic [16:0] a);
        return 16'(a) + 16'h0100;
    endfunction

    // Frame buffer with one cycle of read latency.
    always @(posedge clk) begin
        if (fb_en) fb_rdata <= fb_model(fb_addr);
    end

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every returned word must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        check("valid_exclusive", 32'(disp_valid & aux_valid), 32'd0);
        if (disp_valid || aux_valid) begin
            if (sb_q.size() == 0) begin
                check("unexpected_valid", 32'({disp_valid, aux_valid}), 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("ret_owner_aux", 32'(aux_valid), 32'(e.is_aux));
                check("ret_data", 32'(aux_valid ? aux_data : disp_data), 32'(e.data));
                check("ret_latency", 32'(cyc), 32'(e.due));
            end
        end
    end

    task automatic step(input logic de, input logic [16:0] da, input logic ar, input logic [16:0] aa);
        exp_t e;
        disp_en   = de;
        disp_addr = da;
        aux_req   = ar;
        aux_addr  = aa;
        @(negedge clk);
        check("aux_gnt", 32'(aux_gnt), 32'(!de && ar));
        check("fb_en", 32'(fb_en), 32'(exp_fb_en));
        if (exp_fb_en) check("fb_addr", 32'(fb_addr), 32'(exp_fb_addr));
        if (de) begin
            e = '{is_aux: 1'b0, data: fb_model(da), due: cyc + 3};
            sb_q.push_back(e);
            exp_fb_en   = 1'b1;
            exp_fb_addr = da;
        end else if (ar) begin
            e = '{is_aux: 1'b1, data: fb_model(aa), due: cyc + 3};
            sb_q.push_back(e);
            exp_fb_en   = 1'b1;
            exp_fb_addr = aa;
        end else begin
            exp_fb_en = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 17'd0, 1'b0, 17'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_aux_gnt"},    32'(aux_gnt),    32'd0);
        check({tag, "_fb_en"},      32'(fb_en),      32'd0);
        check({tag, "_fb_addr"},    32'(fb_addr),    32'd0);
        check({tag, "_disp_valid"}, 32'(disp_valid), 32'd0);
        check({tag, "_aux_valid"},  32'(aux_valid),  32'd0);
        check({tag, "_disp_data"},  32'(disp_data),  32'd0);
        check({tag, "_aux_data"},   32'(aux_data),   32'd0);
        check({tag, "_aux_starve"}, 32'(aux_starve), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [16:0] a;
        rst_n       = 1'b0;
        disp_en     = 1'b0;
        disp_addr   = '0;
        aux_req     = 1'b1;
        aux_addr    = 17'd5;
        exp_fb_en   = 1'b0;
        exp_fb_addr = '0;
`ifdef FB_ARB_STATS_EN
        stats_clr   = 1'b0;
`endif
        // Reset state, with aux_req high to confirm no grant during reset.
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        aux_req = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Display burst, addresses 0..3.
        for (int i = 0; i < 4; i++) step(1'b1, 17'(i), 1'b0, 17'd0);
        idle(4);

        // Aux held high at the last pixel address: one grant per free cycle.
        for (int i = 0; i < 3; i++) step(1'b0, 17'd0, 1'b1, 17'd76799);
        idle(4);

        // Display alternating with a held aux request.
        a = 17'd100;
        for (int k = 0; k < 8; k++) begin
            if ((k % 2) == 0) step(1'b1, 17'(200 + k), 1'b1, a);
            else begin
                step(1'b0, 17'd0, 1'b1, a);
                a = a + 17'd1;
            end
        end
        idle(4);

        // Withdrawn request (dropped while display busy) issues nothing.
        step(1'b1, 17'd300, 1'b1, 17'd900);
        idle(4);

        // Starvation: 1022 blocked cycles stay below the limit, the 1023rd reaches it.
        for (int i = 0; i < 1022; i++) step(1'b1, 17'(i), 1'b1, 17'd500);
        check("starve_below_limit", 32'(aux_starve), 32'd0);
        step(1'b1, 17'd1022, 1'b1, 17'd500);
        check("starve_at_limit", 32'(aux_starve), 32'd1);
        step(1'b1, 17'd1023, 1'b1, 17'd500);
        check("starve_saturated", 32'(aux_starve), 32'd1);
        step(1'b0, 17'd0, 1'b1, 17'd500);
        check("starve_cleared", 32'(aux_starve), 32'd0);
        idle(4);

        // Reset while two reads are in flight.
        step(1'b1, 17'd10, 1'b0, 17'd0);
        step(1'b0, 17'd0, 1'b1, 17'd20);
        rst_n   = 1'b0;
        disp_en = 1'b0;
        aux_req = 1'b0;
        sb_q.delete();
        exp_fb_en   = 1'b0;
        exp_fb_addr = '0;
        @(negedge clk);
        check_reset_outputs("midreset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 17'd0, 1'b0, 17'd0);
            check("no_stale_valid", 32'(disp_valid | aux_valid), 32'd0);
        end
        step(1'b1, 17'd7, 1'b0, 17'd0);
        idle(4);

`ifdef FB_ARB_STATS_EN
        stats_clr = 1'b1;
        idle(1);
        stats_clr = 1'b0;
        for (int i = 0; i < 7; i++) step(1'b1, 17'(40 + i), 1'b0, 17'd0);
        for (int i = 0; i < 5; i++) step(1'b0, 17'd0, 1'b1, 17'(60 + i));
        check("aux_grant_cnt", 32'(aux_grant_cnt), 32'd5);
        check("disp_read_cnt", 32'(disp_read_cnt), 32'd7);
        stats_clr = 1'b1;
        step(1'b0, 17'd0, 1'b1, 17'd70);
        stats_clr = 1'b0;
        check("aux_grant_cnt_clr", 32'(aux_grant_cnt), 32'd0);
        check("disp_read_cnt_clr", 32'(disp_read_cnt), 32'd0);
        idle(4);
`endif

        idle(6);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
